// File: rtl/mul_seq_ctrl_if.sv
// Request/result handshake bundle for mul_seq_ctrl.
// Ports: request valid/ready/op/a/b, result valid/ready/result.
interface mul_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  modport master (
    output in_valid,
    output in_op,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Multicycle RV32M multiply sequencer around an unsigned 32x32 array.
// Ports: clk, rst (sync, high), flush, bus (slave handshakes), busy.
module Multiplier32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_p
);
  // Plain product; synthesis maps it onto a compressor tree.
  assign o_p = {32'd0, i_a} * {32'd0, i_b};
endmodule

module mul_seq_ctrl #(
  parameter int unsigned CALC_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  mul_seq_ctrl_if.slave bus,
  output logic          busy
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD =
    4'(CALC_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_neg;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic [31:0] r_result;

  logic        w_accept;
  logic        w_capture;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_prod;
  logic [63:0] w_prod_s;

  assign bus.in_ready   = (r_state == S_IDLE) & ~flush;
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_result = r_result;
  assign busy           = (r_state != S_IDLE);

  assign w_accept   = bus.in_valid & bus.in_ready;
  assign w_capture  = (r_state == S_CALC) &
                      (r_cnt == 4'd0) & ~flush;

  assign w_a_signed = (bus.in_op == 2'b01) |
                      (bus.in_op == 2'b10);
  assign w_b_signed = (bus.in_op == 2'b01);
  assign w_a_neg    = w_a_signed & bus.in_a[31];
  assign w_b_neg    = w_b_signed & bus.in_b[31];

  // Only the magnitude registers feed the array, so the
  // tree path is stable for the whole CALC window.
  Multiplier32 u_mul (
    .i_a (r_mag_a),
    .i_b (r_mag_b),
    .o_p (w_prod)
  );

  assign w_prod_s = r_neg ? (~w_prod + 64'd1) : w_prod;

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      flush:
        w_state_nxt = S_IDLE;
      (!flush && r_state == S_IDLE && bus.in_valid):
        w_state_nxt = S_CALC;
      (!flush && r_state == S_CALC && r_cnt == 4'd0):
        w_state_nxt = S_DONE;
      (!flush && r_state == S_DONE && bus.out_ready):
        w_state_nxt = S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_op     <= 2'b00;
      r_neg    <= 1'b0;
      r_mag_a  <= 32'd0;
      r_mag_b  <= 32'd0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op    <= bus.in_op;
        r_neg   <= w_a_neg ^ w_b_neg;
        r_mag_a <= w_a_neg ? -bus.in_a : bus.in_a;
        r_mag_b <= w_b_neg ? -bus.in_b : bus.in_b;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == S_CALC && !flush &&
                   r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_result <= (r_op == 2'b00) ? w_prod_s[31:0]
                                    : w_prod_s[63:32];
      end
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed cases plus random back-to-back
// runs on three instances (CALC_CYCLES 2, 1, 15) against a model.
module tb_mul_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic flush;

  logic        s_iv  [3];
  logic [1:0]  s_op  [3];
  logic [31:0] s_a   [3];
  logic [31:0] s_b   [3];
  logic        s_or  [3];
  logic        s_ir  [3];
  logic        s_ov  [3];
  logic [31:0] s_res [3];
  logic        s_busy[3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CC =
      (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    mul_seq_ctrl_if bus ();
    assign bus.in_valid  = s_iv[g];
    assign bus.in_op     = s_op[g];
    assign bus.in_a      = s_a[g];
    assign bus.in_b      = s_b[g];
    assign bus.out_ready = s_or[g];
    assign s_ir[g]       = bus.in_ready;
    assign s_ov[g]       = bus.out_valid;
    assign s_res[g]      = bus.out_result;
    mul_seq_ctrl #(.CALC_CYCLES(CC)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave),
      .busy  (s_busy[g])
    );
  end

  function automatic int cc_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  // Reference: extend each operand to 64 bits per its
  // signedness, multiply modulo 2^64, pick the half.
  function automatic logic [31:0] ref_mul(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ?
         {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(
    input int k,
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int n;
    n = 0;
    while (s_ir[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 32'(s_ir[k]), 32'd1);
    s_iv[k] = 1'b1;
    s_op[k] = op;
    s_a[k]  = a;
    s_b[k]  = b;
    @(negedge clk);
    s_iv[k] = 1'b0;
  endtask

  task automatic wait_ov(input int k, output int lat);
    lat = 1;
    while (s_ov[k] !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("wait_valid", 32'(s_ov[k]), 32'd1);
  endtask

  task automatic run_op(
    input string tag,
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] exp
  );
    int lat;
    s_or[0] = 1'b1;
    issue(0, op, a, b);
    wait_ov(0, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_res"}, s_res[0], exp);
    @(negedge clk);
    chk({tag, "_ov_low"}, 32'(s_ov[0]), 32'd0);
    chk({tag, "_ir_back"}, 32'(s_ir[0]), 32'd1);
  endtask

  task automatic b2b(input int k);
    logic [31:0] expq[$];
    logic [31:0] e;
    int n;
    int last;
    int acc;
    int got;
    int budget;
    logic renew;
    budget = 100 * (cc_of(k) + 2) + 100;
    n = 0;
    last = -1;
    acc = 0;
    got = 0;
    renew = 1'b1;
    s_or[k] = 1'b1;
    s_iv[k] = 1'b1;
    while (got < 100 && n < budget) begin
      if (renew) begin
        s_op[k] = 2'($urandom_range(3));
        s_a[k]  = rnd_opnd();
        s_b[k]  = rnd_opnd();
        renew = 1'b0;
      end
      if (acc == 100) s_iv[k] = 1'b0;
      if (s_ov[k] === 1'b1) begin
        e = (expq.size() > 0) ? expq.pop_front() : 32'hx;
        chk("b2b_res", s_res[k], e);
        got++;
      end
      if (s_ir[k] === 1'b1 && s_iv[k] === 1'b1) begin
        expq.push_back(ref_mul(s_op[k], s_a[k], s_b[k]));
        if (last >= 0)
          chk("b2b_period", 32'(n - last),
              32'(cc_of(k) + 2));
        last = n;
        acc++;
        renew = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    chk("b2b_count", 32'(got), 32'd100);
    s_iv[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] old;
    int lat;
    for (int k = 0; k < 3; k++) begin
      s_iv[k] = 1'b0;
      s_op[k] = 2'b00;
      s_a[k]  = 32'd0;
      s_b[k]  = 32'd0;
      s_or[k] = 1'b0;
    end
    rst = 1'b1;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ov", 32'(s_ov[0]), 32'd0);
    chk("rst_busy", 32'(s_busy[0]), 32'd0);
    chk("rst_res", s_res[0], 32'd0);
    chk("rst_ir", 32'(s_ir[0]), 32'd1);

    run_op("mul", 2'b00, 32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1);
    run_op("mulh_min", 2'b01, 32'h8000_0000,
           32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu", 2'b10, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_zero", 2'b01, 32'd0,
           32'h8000_0000, 32'd0);

    // Backpressure
    s_or[0] = 1'b0;
    exp = ref_mul(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(0, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_ov(0, lat);
    for (int i = 0; i < 10; i++) begin
      chk("bp_ov", 32'(s_ov[0]), 32'd1);
      chk("bp_res", s_res[0], exp);
      chk("bp_ir", 32'(s_ir[0]), 32'd0);
      @(negedge clk);
    end
    s_or[0] = 1'b1;
    s_iv[0] = 1'b1;
    s_op[0] = 2'b00;
    s_a[0]  = 32'd7;
    s_b[0]  = 32'd6;
    @(negedge clk);
    chk("bp_rel_ov", 32'(s_ov[0]), 32'd0);
    chk("bp_rel_ir", 32'(s_ir[0]), 32'd1);
    @(negedge clk);
    s_iv[0] = 1'b0;
    chk("bp_acc_busy", 32'(s_busy[0]), 32'd1);
    wait_ov(0, lat);
    chk("bp_second", s_res[0], 32'd42);
    @(negedge clk);

    // Flush in first CALC cycle
    old = s_res[0];
    issue(0, 2'b00, 32'h0000_1234, 32'h0000_5678);
    chk("fl_busy", 32'(s_busy[0]), 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_ir_low", 32'(s_ir[0]), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fl_busy_low", 32'(s_busy[0]), 32'd0);
      chk("fl_ov_low", 32'(s_ov[0]), 32'd0);
      chk("fl_res_kept", s_res[0], old);
      @(negedge clk);
    end
    run_op("fl_next", 2'b11, 32'd2, 32'd3, 32'd0);

    // Flush in DONE with out_ready high
    s_or[0] = 1'b0;
    issue(0, 2'b00, 32'd5, 32'd5);
    wait_ov(0, lat);
    flush = 1'b1;
    s_or[0] = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fld_ov", 32'(s_ov[0]), 32'd0);
    chk("fld_busy", 32'(s_busy[0]), 32'd0);

    // Reset while DONE and out_ready high
    s_or[0] = 1'b0;
    issue(0, 2'b00, 32'd9, 32'd9);
    wait_ov(0, lat);
    chk("rd_res_pre", s_res[0], 32'd81);
    rst = 1'b1;
    s_or[0] = 1'b1;
    @(negedge clk);
    chk("rd_ov", 32'(s_ov[0]), 32'd0);
    chk("rd_busy", 32'(s_busy[0]), 32'd0);
    chk("rd_res", s_res[0], 32'd0);
    chk("rd_ir", 32'(s_ir[0]), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 3; k++) b2b(k);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing controller around the 32-bit unsigned Wallace-tree multiplier (`Multiplier32`, instantiated inside this block). It accepts one multiply request at a time over a valid/ready handshake and handles the four RV32M multiply flavours by sign-magnitude conversion around the unsigned array. It holds operands stable for a configurable number of settle cycles, so the combinational tree can be constrained as a multicycle path. It returns a registered 32-bit result over a second valid/ready handshake, and sits between the execute-stage issue logic and writeback.

## Interface
- `CALC_CYCLES`, default 2, settle cycles spent in CALC; legal range 1..15; 4-bit counter.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  synchronous abort of any in-flight request.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept; `in_ready = (state==IDLE) & !flush`.
- `in_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_a`  in  32  multiplicand (rs1).
- `in_b`  in  32  multiplier (rs2).
- `out_valid`  out  1  result valid; high exactly in DONE.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  32  registered result.
- `busy`  out  1  state != IDLE.

## Operation
- **States and transitions:**
  - IDLE → CALC on accept (`in_valid & in_ready`).
  - CALC → DONE when the counter reaches 0.
  - DONE → IDLE on `out_valid & out_ready`.
  - Any state → IDLE on `flush` or `rst`.
- **Accept (IDLE, handshake):**
  - Latch `op_q`.
  - a_signed = op∈{01,10}; b_signed = op==01.
  - `mag_a` = a_signed & in_a[31] ? -in_a : in_a. `mag_b` likewise.
  - `neg_q` = (a_signed & in_a[31]) ^ (b_signed & in_b[31]).
  - Counter loads CALC_CYCLES-1.
- **Magnitude edge case:**
  - Magnitudes are 32-bit unsigned; -2^31 maps to 0x80000000, which is correct as unsigned.
  - Operand 0 with a sign bit is impossible, so neg_q with a zero product still yields 0.
- **Multiplier:** `Multiplier32` is driven only from `mag_a`/`mag_b` registers, which are stable for all of CALC.
- **CALC:**
  - Counter decrements each cycle.
  - In the cycle with counter==0, capture into `out_result`:
    - p = neg_q ? (~prod64 + 1) : prod64, 64-bit two's complement, wraps modulo 2^64.
    - `out_result` = op==00 ? p[31:0] : p[63:32].
  - The state then moves to DONE.
- **DONE:**
  - `out_result` and `out_valid` are held unchanged until `out_ready`.
  - No new request is accepted in DONE.
- **Flush/reset priority:**
  - `rst` beats `flush`; `flush` beats every handshake in the same cycle.
  - A flush in DONE discards the result even when `out_ready` is high.
- **Reset values:** state IDLE, `out_valid` 0, `busy` 0, `out_result` 0x00000000, counter 0, `op_q`/`neg_q`/`mag_a`/`mag_b` 0. `in_ready` is 1 in the first cycle after reset if `flush` is low.

## Timing
- **Latency:**
  - Accept at the edge ending cycle t.
  - CALC occupies cycles t+1 .. t+CALC_CYCLES.
  - `out_valid` is high from cycle t+CALC_CYCLES+1.
  - For the default, the result is visible 3 cycles after the accept edge.
- **Throughput:**
  - With `out_ready` held high, the period is CALC_CYCLES+2 cycles per op (4 at default).
  - `in_ready` rises in the cycle after the output handshake.
- **Backpressure:** `out_ready` low keeps DONE indefinitely with `out_result` stable; `in_ready` stays 0.
- **Outputs:** `in_ready`, `out_valid` and `busy` are functions of registered state plus `flush` only. There is no combinational path from `in_valid` or `out_ready` to any output.
- **Multicycle constraint:** the `mag_*` → `out_result` path gets a multicycle path of CALC_CYCLES.
- **Flush/reset mid-CALC:** state is IDLE the next cycle, `out_valid` never rises for that request, and `out_result` keeps its old value.

## Test plan
- **MUL:** MUL a=3, b=0xFFFFFFFB (−5), CALC_CYCLES=2 → `out_valid` 3 cycles after accept, `out_result`=0xFFFFFFF1.
- **High-half ops:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF.
  - MULH 0×0x80000000 → 0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE → `out_result`/`out_valid` stable and `in_ready`=0 throughout. Release → IDLE next cycle, and a second request is accepted the following cycle.
- **Flush mid-CALC:** assert `flush` in the first CALC cycle → state IDLE, `out_valid` stays 0, and a next request MULHU 2×3 returns 0x00000000 with no stale result.
- **Reset mid-DONE:** `rst` with `out_valid`=1 and `out_ready`=1 → next cycle all outputs at reset values and no handshake counted.
- **Back-to-back throughput:** 100 random ops with `in_valid` and `out_ready` always 1, for CALC_CYCLES ∈ {1,2,15} → each result matches the 64-bit reference model, with exactly CALC_CYCLES+2 cycles between accepts.
